alu_issuer: RTL and testbench

//  Command-side driver for the fixed-point ALU (complex multiply / divide / add units).
//  - Accepts one operation per valid/ready handshake.
//  - Drives enable_alu/instr/dataA/dataB and holds them stable until the ALU returns valid.
//  - Captures data_out/zero into a result register offered on a valid/ready output.
//  - Bounds every operation with a timeout so a hung unit cannot stall the datapath.

---
 rtl/alu_issuer.sv | 155 +++++++++++++++
 tb/tb_alu_issuer.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issuer.sv
// Command-side issuer for the fixed-point ALU: accepts one operation, holds the ALU
// inputs until the unit answers or the timeout expires, then offers the result.
module alu_issuer #(
    parameter int N       = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [2:0]          cmd_instr,
    input  logic signed [N-1:0] cmd_a,
    input  logic signed [N-1:0] cmd_b,
    output logic                enable_alu,
    output logic [2:0]          instr,
    output logic signed [N-1:0] dataA,
    output logic signed [N-1:0] dataB,
    input  logic                alu_valid,
    input  logic                alu_zero,
    input  logic signed [N-1:0] alu_data,
    output logic                res_valid,
    input  logic                res_ready,
    output logic signed [N-1:0] res_data,
    output logic                res_zero,
    output logic                res_timeout,
    output logic                busy
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP,
        S_GAP
    } state_t;

    state_t              state_q, state_d;
    logic                cmd_ready_q, cmd_ready_d;
    logic                en_q, en_d;
    logic [2:0]          instr_q, instr_d;
    logic signed [N-1:0] a_q, a_d;
    logic signed [N-1:0] b_q, b_d;
    logic                res_valid_q, res_valid_d;
    logic signed [N-1:0] res_data_q, res_data_d;
    logic                res_zero_q, res_zero_d;
    logic                res_to_q, res_to_d;
    logic [CW-1:0]       cnt_q, cnt_d;

    always_comb begin
        state_d    = state_q;
        en_d       = en_q;
        instr_d    = instr_q;
        a_d        = a_q;
        b_d        = b_q;
        res_data_d = res_data_q;
        res_zero_d = res_zero_q;
        res_to_d   = res_to_q;
        cnt_d      = cnt_q;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    instr_d = cmd_instr;
                    a_d     = cmd_a;
                    b_d     = cmd_b;
                    cnt_d   = '0;
                    // Illegal opcodes never reach the ALU; answer with a zero result at once.
                    if (cmd_instr[2:1] == 2'b11) begin
                        state_d    = S_RESP;
                        en_d       = 1'b0;
                        res_data_d = '0;
                        res_zero_d = 1'b1;
                        res_to_d   = 1'b0;
                    end else begin
                        state_d = S_WAIT;
                        en_d    = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q + CW'(1);
                // A result arriving on the timeout cycle still counts as a real result.
                if (alu_valid) begin
                    state_d    = S_RESP;
                    en_d       = 1'b0;
                    res_data_d = alu_data;
                    res_zero_d = alu_zero;
                    res_to_d   = 1'b0;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    state_d    = S_RESP;
                    en_d       = 1'b0;
                    res_data_d = '0;
                    res_zero_d = 1'b1;
                    res_to_d   = 1'b1;
                end
            end
            S_RESP: begin
                if (res_ready) begin
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                en_d    = 1'b0;
            end
        endcase

        res_valid_d = (state_d == S_RESP);
        cmd_ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cmd_ready_q <= 1'b0;
            en_q        <= 1'b0;
            instr_q     <= '0;
            a_q         <= '0;
            b_q         <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_zero_q  <= 1'b0;
            res_to_q    <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            en_q        <= en_d;
            instr_q     <= instr_d;
            a_q         <= a_d;
            b_q         <= b_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_zero_q  <= res_zero_d;
            res_to_q    <= res_to_d;
            cnt_q       <= cnt_d;
        end
    end

    assign cmd_ready   = cmd_ready_q;
    assign enable_alu  = en_q;
    assign instr       = instr_q;
    assign dataA       = a_q;
    assign dataB       = b_q;
    assign res_valid   = res_valid_q;
    assign res_data    = res_data_q;
    assign res_zero    = res_zero_q;
    assign res_timeout = res_to_q;
    assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_alu_issuer.sv
// Bench for alu_issuer: a latency-programmable ALU model plus a per-operation
// reference of expected result, latency and enable duration.
module tb_alu_issuer;

    localparam int N  = 32;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [2:0]    cmd_instr = '0;
    logic [N-1:0]  cmd_a = '0;
    logic [N-1:0]  cmd_b = '0;
    logic          enable_alu;
    logic [2:0]    instr;
    logic [N-1:0]  dataA;
    logic [N-1:0]  dataB;
    logic          alu_valid;
    logic          alu_zero;
    logic [N-1:0]  alu_data;
    logic          res_valid;
    logic          res_ready = 1'b0;
    logic [N-1:0]  res_data;
    logic          res_zero;
    logic          res_timeout;
    logic          busy;

    int n_checks = 0;
    int n_err    = 0;

    int            alu_lat   = 0;
    bit            alu_hang  = 1'b0;
    bit            alu_force = 1'b0;
    int            en_cnt    = 0;
    bit            bp_hold   = 1'b0;
    logic [2:0]    bp_instr  = '0;
    logic [N-1:0]  bp_a      = '0;
    logic [N-1:0]  bp_b      = '0;

    alu_issuer #(.N(N), .TIMEOUT(TO)) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_instr  (cmd_instr),
        .cmd_a      (cmd_a),
        .cmd_b      (cmd_b),
        .enable_alu (enable_alu),
        .instr      (instr),
        .dataA      (dataA),
        .dataB      (dataB),
        .alu_valid  (alu_valid),
        .alu_zero   (alu_zero),
        .alu_data   (alu_data),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_zero   (res_zero),
        .res_timeout(res_timeout),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Q16.16 arithmetic of the real units
    function automatic logic [31:0] alu_fn(input logic [2:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
        longint sa, sb, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op[2:1])
            2'b00:   r = (sa * sb) >>> 16;
            2'b01:   r = (sb == 0) ? 64'sd0 : (sa * 65536) / sb;
            2'b10:   r = sa + sb;
            default: r = 0;
        endcase
        return r[31:0];
    endfunction

    // ALU model: answers once enable has been high for alu_lat earlier cycles
    always @(posedge clk) en_cnt <= enable_alu ? en_cnt + 1 : 0;
    assign alu_valid = alu_force | (enable_alu & ~alu_hang & (en_cnt == alu_lat));
    assign alu_data  = alu_force ? 32'hDEADBEEF : alu_fn(instr, dataA, dataB);
    assign alu_zero  = alu_force ? 1'b1 : (alu_data == '0);

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int lat, input bit hang, input int rr_delay);
        int k, en_seen, waitc, exp_lat, exp_en;
        logic [31:0] exp_d, held_d;
        logic exp_z, exp_t;
        if (op[2:1] == 2'b11) begin
            exp_en = 0; exp_lat = 1; exp_d = '0; exp_z = 1'b1; exp_t = 1'b0;
        end else if (hang || lat > TO - 1) begin
            exp_en = TO; exp_lat = TO + 1; exp_d = '0; exp_z = 1'b1; exp_t = 1'b1;
        end else begin
            exp_en = lat + 1; exp_lat = lat + 2; exp_d = alu_fn(op, a, b);
            exp_z = (exp_d == '0); exp_t = 1'b0;
        end
        alu_lat   = lat;
        alu_hang  = hang;
        cmd_valid = 1'b1;
        cmd_instr = op;
        cmd_a     = a;
        cmd_b     = b;
        waitc = 0;
        while (!cmd_ready && waitc < 20) begin
            tick();
            waitc++;
        end
        chk("accept_wait", waitc, 0);
        tick();
        cmd_valid = 1'b0;
        cmd_instr = 3'($urandom);
        cmd_a     = $urandom;
        cmd_b     = $urandom;
        en_seen = 0;
        k = 1;
        while (!res_valid && k <= 40) begin
            if (enable_alu) begin
                en_seen++;
                chk("instr_held", instr, op);
                chk("dataA_held", dataA, a);
                chk("dataB_held", dataB, b);
            end
            chk("cmd_ready_in_wait", cmd_ready, 1'b0);
            tick();
            k++;
        end
        chk("latency", k, exp_lat);
        chk("enable_cycles", en_seen, exp_en);
        chk("res_data", res_data, exp_d);
        chk("res_zero", res_zero, exp_z);
        chk("res_timeout", res_timeout, exp_t);
        chk("enable_in_resp", enable_alu, 1'b0);
        chk("busy_in_resp", busy, 1'b1);
        held_d = res_data;
        for (int i = 0; i < rr_delay; i++) begin
            if (bp_hold) begin
                cmd_valid = 1'b1;
                cmd_instr = bp_instr;
                cmd_a     = bp_a;
                cmd_b     = bp_b;
            end
            alu_force = 1'b1;
            tick();
            chk("bp_res_valid", res_valid, 1'b1);
            chk("bp_res_data", res_data, held_d);
            chk("bp_cmd_ready", cmd_ready, 1'b0);
        end
        alu_force = 1'b0;
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk("gap_res_valid", res_valid, 1'b0);
        chk("gap_enable", enable_alu, 1'b0);
        chk("gap_cmd_ready", cmd_ready, 1'b0);
        tick();
        chk("idle_cmd_ready", cmd_ready, 1'b1);
        chk("idle_busy", busy, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        repeat (3) tick();
        chk("rst_enable", enable_alu, 1'b0);
        chk("rst_instr", instr, 3'b000);
        chk("rst_dataA", dataA, 32'h0);
        chk("rst_dataB", dataB, 32'h0);
        chk("rst_res_valid", res_valid, 1'b0);
        chk("rst_res_data", res_data, 32'h0);
        chk("rst_res_zero", res_zero, 1'b0);
        chk("rst_res_timeout", res_timeout, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_cmd_ready", cmd_ready, 1'b0);
        rst = 1'b0;
        tick();
        chk("post_rst_cmd_ready", cmd_ready, 1'b1);
        chk("post_rst_busy", busy, 1'b0);

        run_op(3'b100, 32'h00018000, 32'h00020000, 0, 1'b0, 0);
        run_op(3'b000, 32'h00018000, 32'h00020000, 5, 1'b0, 0);
        run_op(3'b010, 32'h00010000, 32'h00020000, 0, 1'b1, 0);
        run_op(3'b100, 32'h00000005, 32'hFFFFFFFB, 0, 1'b0, 1);

        bp_hold  = 1'b1;
        bp_instr = 3'b101;
        bp_a     = 32'h00000007;
        bp_b     = 32'h00000009;
        run_op(3'b001, 32'h00030000, 32'h00020000, 2, 1'b0, 10);
        bp_hold  = 1'b0;
        run_op(3'b101, 32'h00000007, 32'h00000009, 0, 1'b0, 0);

        run_op(3'b110, 32'h00000005, 32'h00000006, 0, 1'b0, 0);
        run_op(3'b011, 32'h00050000, 32'h00020000, TO - 1, 1'b0, 0);

        // reset in the middle of a hung divide
        alu_hang  = 1'b1;
        cmd_valid = 1'b1;
        cmd_instr = 3'b010;
        cmd_a     = 32'h00010000;
        cmd_b     = 32'h00030000;
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        chk("midrst_enable_before", enable_alu, 1'b1);
        rst = 1'b1;
        tick();
        chk("midrst_enable", enable_alu, 1'b0);
        chk("midrst_res_valid", res_valid, 1'b0);
        chk("midrst_busy", busy, 1'b0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("midrst_no_result", res_valid, 1'b0);
        end
        chk("midrst_cmd_ready", cmd_ready, 1'b1);

        for (int n = 0; n < 40; n++) begin
            logic [2:0] op;
            op = 3'($urandom_range(0, 7));
            if (op[2:1] == 2'b11 && $urandom_range(0, 2) != 0) op = 3'b100;
            run_op(op, $urandom, $urandom, $urandom_range(0, 9),
                   ($urandom_range(0, 7) == 0), $urandom_range(0, 3));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
